// File: rtl/axi_ram.sv
// axi_ram: AXI4 slave in front of a dual-port, byte-enabled RAM.
// Write and read channels are served by independent FSMs, so a write burst and
// a read burst can make progress in the same cycle.
module axi_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int ID_WIDTH   = 9
) (
   input  logic                  clk,
   input  logic                  rst,
   // write address channel
   input  logic [ID_WIDTH-1:0]   s_axi_awid,
   input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
   input  logic [7:0]            s_axi_awlen,
   input  logic [2:0]            s_axi_awsize,
   input  logic [1:0]            s_axi_awburst,
   input  logic                  s_axi_awvalid,
   output logic                  s_axi_awready,
   // write data channel
   input  logic [DATA_WIDTH-1:0] s_axi_wdata,
   input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
   input  logic                  s_axi_wlast,
   input  logic                  s_axi_wvalid,
   output logic                  s_axi_wready,
   // write response channel
   output logic [ID_WIDTH-1:0]   s_axi_bid,
   output logic [1:0]            s_axi_bresp,
   output logic                  s_axi_bvalid,
   input  logic                  s_axi_bready,
   // read address channel
   input  logic [ID_WIDTH-1:0]   s_axi_arid,
   input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
   input  logic [7:0]            s_axi_arlen,
   input  logic [2:0]            s_axi_arsize,
   input  logic [1:0]            s_axi_arburst,
   input  logic                  s_axi_arvalid,
   output logic                  s_axi_arready,
   // read data channel
   output logic [ID_WIDTH-1:0]   s_axi_rid,
   output logic [DATA_WIDTH-1:0] s_axi_rdata,
   output logic [1:0]            s_axi_rresp,
   output logic                  s_axi_rlast,
   output logic                  s_axi_rvalid,
   input  logic                  s_axi_rready
);

   localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
   localparam int WORD_WIDTH = ADDR_WIDTH - ADDR_LSB;
   localparam int DEPTH      = 2 ** WORD_WIDTH;

   typedef enum logic [1:0] {W_IDLE, W_BURST, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_BURST}         r_state_t;

   // Address of the following beat: FIXED holds, anything else steps by 2^size.
   // The sum is ADDR_WIDTH wide, so bursts wrap at the top of memory.
   function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                       input logic [2:0]            size,
                                                       input logic [1:0]            burst);
      logic [ADDR_WIDTH-1:0] step;
      step = {{(ADDR_WIDTH-1){1'b0}}, 1'b1} << size;
      return (burst == 2'b00) ? addr : addr + step;
   endfunction

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   w_state_t              w_state, w_next;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [7:0]            w_cnt;
   logic [2:0]            w_size;
   logic [1:0]            w_burst;

   r_state_t              r_state, r_next;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [7:0]            r_cnt;
   logic [2:0]            r_size;
   logic [1:0]            r_burst;

   logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

   // The beat counter alone decides where a write burst ends.
   logic unused_wlast;
   assign unused_wlast = s_axi_wlast;

   assign aw_hs = s_axi_awvalid && s_axi_awready;
   assign w_hs  = s_axi_wvalid  && s_axi_wready;
   assign b_hs  = s_axi_bvalid  && s_axi_bready;
   assign ar_hs = s_axi_arvalid && s_axi_arready;
   assign r_hs  = s_axi_rvalid  && s_axi_rready;

   assign s_axi_bresp = 2'b00;
   assign s_axi_rresp = 2'b00;

   // ---------------------------------------------------------------- write path

   // Write FSM state register.
   always_ff @(posedge clk) begin
      if (rst) w_state <= W_IDLE;
      else     w_state <= w_next;
   end

   // Write FSM next-state logic.
   always_comb begin
      // NOTE: next-state gets a default before the case so no path leaves it unassigned (no latch).
      w_next = w_state;
      case (w_state)
         W_IDLE:  if (aw_hs)                   w_next = W_BURST;
         W_BURST: if (w_hs && w_cnt == 8'd0)   w_next = W_RESP;
         W_RESP:  if (b_hs)                    w_next = W_IDLE;
         default:                              w_next = W_IDLE;
      endcase
   end

   // Write handshake outputs are registered from the next state; burst context is captured on AW.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_axi_awready <= 1'b0;
         s_axi_wready  <= 1'b0;
         s_axi_bvalid  <= 1'b0;
         s_axi_bid     <= '0;
         w_addr        <= '0;
         w_cnt         <= '0;
         w_size        <= '0;
         w_burst       <= '0;
      end else begin
         s_axi_awready <= (w_next == W_IDLE);
         s_axi_wready  <= (w_next == W_BURST);
         s_axi_bvalid  <= (w_next == W_RESP);
         if (aw_hs) begin
            s_axi_bid <= s_axi_awid;
            w_addr    <= s_axi_awaddr;
            w_cnt     <= s_axi_awlen;
            w_size    <= s_axi_awsize;
            w_burst   <= s_axi_awburst;
         end
         if (w_hs) begin
            w_addr <= next_addr(w_addr, w_size, w_burst);
            w_cnt  <= w_cnt - 8'd1;
         end
      end
   end

   // Memory write port: only the byte lanes enabled by wstrb are updated.
   always_ff @(posedge clk) begin
      // NOTE: the RAM array is deliberately left out of reset so contents survive rst and it maps onto block RAM.
      if (w_hs && !rst) begin
         for (int i = 0; i < STRB_WIDTH; i++) begin
            if (s_axi_wstrb[i])
               mem[w_addr[ADDR_WIDTH-1:ADDR_LSB]][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
         end
      end
   end

   // ----------------------------------------------------------------- read path

   // Read FSM state register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= R_IDLE;
      else     r_state <= r_next;
   end

   // Read FSM next-state logic.
   always_comb begin
      r_next = r_state;
      if (r_state == R_IDLE) begin
         if (ar_hs) r_next = R_BURST;
      end else begin
         if (r_hs && r_cnt == 8'd0) r_next = R_IDLE;
      end
   end

   // Read data register: loaded on AR and on every accepted beat that has a successor,
   // held otherwise so rdata/rlast stay put under backpressure. r_addr points at the next beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_axi_arready <= 1'b0;
         s_axi_rvalid  <= 1'b0;
         s_axi_rlast   <= 1'b0;
         s_axi_rid     <= '0;
         s_axi_rdata   <= '0;
         r_addr        <= '0;
         r_cnt         <= '0;
         r_size        <= '0;
         r_burst       <= '0;
      end else begin
         s_axi_arready <= (r_next == R_IDLE);
         s_axi_rvalid  <= (r_next == R_BURST);
         if (ar_hs) begin
            // NOTE: non-blocking reads and writes of mem on the same edge make a same-word collision return the old word.
            s_axi_rid   <= s_axi_arid;
            s_axi_rdata <= mem[s_axi_araddr[ADDR_WIDTH-1:ADDR_LSB]];
            s_axi_rlast <= (s_axi_arlen == 8'd0);
            r_addr      <= next_addr(s_axi_araddr, s_axi_arsize, s_axi_arburst);
            r_cnt       <= s_axi_arlen;
            r_size      <= s_axi_arsize;
            r_burst     <= s_axi_arburst;
         end else if (r_hs) begin
            if (r_cnt != 8'd0) begin
               s_axi_rdata <= mem[r_addr[ADDR_WIDTH-1:ADDR_LSB]];
               s_axi_rlast <= (r_cnt == 8'd1);
               r_addr      <= next_addr(r_addr, r_size, r_burst);
               r_cnt       <= r_cnt - 8'd1;
            end else begin
               s_axi_rlast <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_axi_ram.sv
// tb_axi_ram: scoreboard bench for axi_ram. A byte-accurate memory model
// predicts every read beat and write response; expectations are queued when
// the request is issued and compared as the DUT presents each beat.
module tb_axi_ram;

   localparam int DW = 32;
   localparam int AW = 16;
   localparam int SW = 4;
   localparam int IW = 9;

   logic          clk = 1'b0;
   logic          rst;
   logic [IW-1:0] s_axi_awid;
   logic [AW-1:0] s_axi_awaddr;
   logic [7:0]    s_axi_awlen;
   logic [2:0]    s_axi_awsize;
   logic [1:0]    s_axi_awburst;
   logic          s_axi_awvalid, s_axi_awready;
   logic [DW-1:0] s_axi_wdata;
   logic [SW-1:0] s_axi_wstrb;
   logic          s_axi_wlast, s_axi_wvalid, s_axi_wready;
   logic [IW-1:0] s_axi_bid;
   logic [1:0]    s_axi_bresp;
   logic          s_axi_bvalid, s_axi_bready;
   logic [IW-1:0] s_axi_arid;
   logic [AW-1:0] s_axi_araddr;
   logic [7:0]    s_axi_arlen;
   logic [2:0]    s_axi_arsize;
   logic [1:0]    s_axi_arburst;
   logic          s_axi_arvalid, s_axi_arready;
   logic [IW-1:0] s_axi_rid;
   logic [DW-1:0] s_axi_rdata;
   logic [1:0]    s_axi_rresp;
   logic          s_axi_rlast, s_axi_rvalid, s_axi_rready;

   axi_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ID_WIDTH(IW)) dut (
      .clk(clk), .rst(rst),
      .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
      .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
      .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
      .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
      .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
      .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
      .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
      .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
      .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
      logic [IW-1:0] id;
   } rbeat_t;

   rbeat_t        rq[$];
   logic [IW-1:0] bq[$];
   logic [DW-1:0] model_mem [0:16383];
   logic [DW-1:0] wbuf [0:255];
   logic [SW-1:0] sbuf [0:255];
   int            n_checks = 0;
   int            n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [AW-1:0] nxt(input logic [AW-1:0] a, input logic [1:0] burst);
      return (burst == 2'b00) ? a : a + 16'd4;
   endfunction

   // Full write transaction; beat data comes from wbuf/sbuf. bdelay = cycles bready is held low.
   task automatic do_write(input logic [AW-1:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [IW-1:0] id, input int bdelay);
      logic [AW-1:0] a;
      int n;
      s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awsize = 3'd2;
      s_axi_awburst = burst; s_axi_awid = id; s_axi_awvalid = 1'b1;
      n = 0;
      while (!s_axi_awready && n < 50) begin @(negedge clk); n++; end
      check("aw_ready", s_axi_awready, 1'b1);
      @(negedge clk);
      s_axi_awvalid = 1'b0;
      check("aw_drop", s_axi_awready, 1'b0);
      a = addr;
      for (int i = 0; i <= int'(len); i++) begin
         s_axi_wdata = wbuf[i]; s_axi_wstrb = sbuf[i];
         s_axi_wlast = (i == int'(len)); s_axi_wvalid = 1'b1;
         n = 0;
         while (!s_axi_wready && n < 50) begin @(negedge clk); n++; end
         check("w_ready", s_axi_wready, 1'b1);
         for (int j = 0; j < SW; j++)
            if (sbuf[i][j]) model_mem[a[15:2]][8*j +: 8] = wbuf[i][8*j +: 8];
         a = nxt(a, burst);
         @(negedge clk);
      end
      s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
      bq.push_back(id);
      check("b_valid_lat", s_axi_bvalid, 1'b1);
      for (int k = 0; k < bdelay; k++) begin
         check("b_hold_valid", s_axi_bvalid, 1'b1);
         check("b_hold_id", s_axi_bid, bq[0]);
         check("aw_hold", s_axi_awready, 1'b0);
         @(negedge clk);
      end
      s_axi_bready = 1'b1;
      check("b_valid", s_axi_bvalid, 1'b1);
      check("b_id", s_axi_bid, bq[0]);
      check("b_resp", s_axi_bresp, 2'b00);
      void'(bq.pop_front());
      @(negedge clk);
      s_axi_bready = 1'b0;
      check("b_done", s_axi_bvalid, 1'b0);
      check("aw_back", s_axi_awready, 1'b1);
   endtask

   // Full read transaction; pat[cycle%4] drives rready. Held beats are compared each cycle.
   task automatic do_read(input logic [AW-1:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [IW-1:0] id, input logic [3:0] pat);
      logic [AW-1:0] a;
      int n, cyc;
      s_axi_araddr = addr; s_axi_arlen = len; s_axi_arsize = 3'd2;
      s_axi_arburst = burst; s_axi_arid = id; s_axi_arvalid = 1'b1;
      n = 0;
      while (!s_axi_arready && n < 50) begin @(negedge clk); n++; end
      check("ar_ready", s_axi_arready, 1'b1);
      a = addr;
      for (int b = 0; b <= int'(len); b++) begin
         rq.push_back('{data: model_mem[a[15:2]], last: (b == int'(len)), id: id});
         a = nxt(a, burst);
      end
      @(negedge clk);
      s_axi_arvalid = 1'b0;
      check("ar_drop", s_axi_arready, 1'b0);
      cyc = 0;
      while (rq.size() > 0 && cyc < 2000) begin
         s_axi_rready = pat[cyc % 4];
         check("r_valid", s_axi_rvalid, 1'b1);
         check("r_data", s_axi_rdata, rq[0].data);
         check("r_last", s_axi_rlast, rq[0].last);
         check("r_id", s_axi_rid, rq[0].id);
         check("r_resp", s_axi_rresp, 2'b00);
         if (s_axi_rready && s_axi_rvalid) void'(rq.pop_front());
         @(negedge clk);
         cyc++;
      end
      s_axi_rready = 1'b0;
      check("r_drain", rq.size(), 0);
      rq.delete();
      check("r_done", s_axi_rvalid, 1'b0);
      check("ar_back", s_axi_arready, 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int n;
      rst = 1'b1;
      s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0;
      s_axi_awburst = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
      s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
      s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
      s_axi_arburst = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_awready", s_axi_awready, 1'b0);
      check("rst_wready", s_axi_wready, 1'b0);
      check("rst_bvalid", s_axi_bvalid, 1'b0);
      check("rst_arready", s_axi_arready, 1'b0);
      check("rst_rvalid", s_axi_rvalid, 1'b0);
      check("rst_rlast", s_axi_rlast, 1'b0);
      check("rst_bid", s_axi_bid, 0);
      check("rst_rid", s_axi_rid, 0);
      check("rst_rdata", s_axi_rdata, 0);
      check("rst_bresp", s_axi_bresp, 0);
      check("rst_rresp", s_axi_rresp, 0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_awready", s_axi_awready, 1'b1);
      check("post_rst_arready", s_axi_arready, 1'b1);

      // single beat write/read
      wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
      do_write(16'h0010, 8'd0, 2'b01, 9'h005, 0);
      do_read(16'h0010, 8'd0, 2'b01, 9'h011, 4'b1111);

      // INCR burst of four
      for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; end
      do_write(16'h0100, 8'd3, 2'b01, 9'h0A3, 0);
      do_read(16'h0100, 8'd3, 2'b01, 9'h1C2, 4'b1111);

      // byte strobes: expected readback 0xFF00FF00
      wbuf[0] = 32'hFFFFFFFF; sbuf[0] = 4'hF;
      do_write(16'h0040, 8'd0, 2'b01, 9'h001, 0);
      wbuf[0] = 32'h00000000; sbuf[0] = 4'h5;
      do_write(16'h0040, 8'd0, 2'b01, 9'h002, 0);
      do_read(16'h0040, 8'd0, 2'b01, 9'h003, 4'b1111);

      // backpressure on B and R
      wbuf[0] = 32'hCAFE0001; wbuf[1] = 32'hCAFE0002; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
      do_write(16'h0200, 8'd1, 2'b01, 9'h155, 5);
      do_read(16'h0100, 8'd3, 2'b01, 9'h0AA, 4'b1001);

      // FIXED burst: 0x20 ends as C, 0x24 untouched
      wbuf[0] = 32'h11111111; wbuf[1] = 32'h24242424; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
      do_write(16'h0020, 8'd1, 2'b01, 9'h010, 0);
      wbuf[0] = 32'hAAAA0000; wbuf[1] = 32'hBBBB0000; wbuf[2] = 32'hCCCC0000;
      sbuf[0] = 4'hF; sbuf[1] = 4'hF; sbuf[2] = 4'hF;
      do_write(16'h0020, 8'd2, 2'b00, 9'h011, 0);
      do_read(16'h0020, 8'd1, 2'b01, 9'h012, 4'b1111);
      do_read(16'h0020, 8'd2, 2'b00, 9'h013, 4'b0110);

      // address wrap at the top of memory
      wbuf[0] = 32'h7F7F7F7F; wbuf[1] = 32'h01020304; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
      do_write(16'hFFFC, 8'd1, 2'b01, 9'h0F0, 0);
      do_read(16'hFFFC, 8'd1, 2'b01, 9'h0F1, 4'b1111);
      do_read(16'h0000, 8'd0, 2'b01, 9'h0F2, 4'b1111);

      // 256-beat burst
      for (int i = 0; i < 256; i++) begin
         wbuf[i] = 32'(i) * 32'h01010101 ^ 32'h5A000000;
         sbuf[i] = 4'hF;
      end
      do_write(16'h0800, 8'd255, 2'b01, 9'h1FF, 1);
      do_read(16'h0800, 8'd255, 2'b01, 9'h100, 4'b1011);

      // same-cycle read and write of one word: read returns old data
      wbuf[0] = 32'hAAAA5555; sbuf[0] = 4'hF;
      do_write(16'h0300, 8'd0, 2'b01, 9'h020, 0);
      s_axi_awaddr = 16'h0300; s_axi_awlen = 8'd0; s_axi_awsize = 3'd2;
      s_axi_awburst = 2'b01; s_axi_awid = 9'h00C; s_axi_awvalid = 1'b1;
      n = 0;
      while (!s_axi_awready && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
      s_axi_awvalid = 1'b0;
      s_axi_wdata = 32'h12345678; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
      s_axi_araddr = 16'h0300; s_axi_arlen = 8'd0; s_axi_arsize = 3'd2;
      s_axi_arburst = 2'b01; s_axi_arid = 9'h00D; s_axi_arvalid = 1'b1;
      check("col_wready", s_axi_wready, 1'b1);
      check("col_arready", s_axi_arready, 1'b1);
      rq.push_back('{data: model_mem[14'h0C0], last: 1'b1, id: 9'h00D});
      model_mem[14'h0C0] = 32'h12345678;
      bq.push_back(9'h00C);
      @(negedge clk);
      s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_arvalid = 1'b0;
      check("col_rvalid", s_axi_rvalid, 1'b1);
      check("col_rdata", s_axi_rdata, rq[0].data);
      check("col_rlast", s_axi_rlast, rq[0].last);
      check("col_rid", s_axi_rid, rq[0].id);
      check("col_bvalid", s_axi_bvalid, 1'b1);
      check("col_bid", s_axi_bid, bq[0]);
      s_axi_rready = 1'b1; s_axi_bready = 1'b1;
      void'(rq.pop_front());
      void'(bq.pop_front());
      @(negedge clk);
      s_axi_rready = 1'b0; s_axi_bready = 1'b0;
      check("col_r_done", s_axi_rvalid, 1'b0);
      check("col_b_done", s_axi_bvalid, 1'b0);
      do_read(16'h0300, 8'd0, 2'b01, 9'h00E, 4'b1111);

      // reset in the middle of a read burst
      s_axi_araddr = 16'h0800; s_axi_arlen = 8'd7; s_axi_arsize = 3'd2;
      s_axi_arburst = 2'b01; s_axi_arid = 9'h01F; s_axi_arvalid = 1'b1;
      n = 0;
      while (!s_axi_arready && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
      s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
      check("rm_beat0", s_axi_rdata, model_mem[14'h200]);
      @(negedge clk);
      check("rm_beat1", s_axi_rdata, model_mem[14'h201]);
      s_axi_rready = 1'b0; rst = 1'b1;
      @(negedge clk);
      check("rm_rvalid", s_axi_rvalid, 1'b0);
      check("rm_rlast", s_axi_rlast, 1'b0);
      check("rm_arready", s_axi_arready, 1'b0);
      check("rm_awready", s_axi_awready, 1'b0);
      check("rm_rdata", s_axi_rdata, 0);
      check("rm_rid", s_axi_rid, 0);
      check("rm_bid", s_axi_bid, 0);
      rst = 1'b0;
      @(negedge clk);
      check("rm_arready_back", s_axi_arready, 1'b1);
      check("rm_awready_back", s_axi_awready, 1'b1);
      check("rm_rvalid_idle", s_axi_rvalid, 1'b0);
      do_read(16'h0800, 8'd3, 2'b01, 9'h002, 4'b1111);
      do_read(16'h0010, 8'd0, 2'b01, 9'h003, 4'b1111);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/axi_ram.md
AXI_RAM -- requirements
Module: axi_ram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width in bits (8, 16, 32, 64 or 128).
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, byte address width; memory depth = 2^(ADDR_WIDTH-log2(STRB_WIDTH)) words.
REQ-003 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8, byte lanes per word.
REQ-004 SHALL have parameter ID_WIDTH, default 9, transaction ID width, matching the crossbar master-side ID width.
REQ-005 clk  in  1  single clock; all logic on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 s_axi_awid  in  ID_WIDTH  write ID.
REQ-008 s_axi_awaddr  in  ADDR_WIDTH  write start byte address.
REQ-009 s_axi_awlen  in  8  beats minus one.
REQ-010 s_axi_awsize  in  3  log2 bytes per beat, at most log2(STRB_WIDTH).
REQ-011 s_axi_awburst  in  2  00 FIXED; any other value treated as INCR.
REQ-012 s_axi_awvalid / s_axi_awready  in / out  1 each  AW handshake.
REQ-013 s_axi_wdata  in  DATA_WIDTH  write data.
REQ-014 s_axi_wstrb  in  STRB_WIDTH  byte enables.
REQ-015 s_axi_wlast  in  1  ignored; the beat count governs.
REQ-016 s_axi_wvalid / s_axi_wready  in / out  1 each  W handshake.
REQ-017 s_axi_bid  out  ID_WIDTH  captured awid.
REQ-018 s_axi_bresp  out  2  always 00 (OKAY).
REQ-019 s_axi_bvalid / s_axi_bready  out / in  1 each  B handshake.
REQ-020 s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst  in  ID_WIDTH, ADDR_WIDTH, 8, 3, 2  read address fields, same meaning as AW.
REQ-021 s_axi_arvalid / s_axi_arready  in / out  1 each  AR handshake.
REQ-022 s_axi_rid  out  ID_WIDTH  captured arid.
REQ-023 s_axi_rdata  out  DATA_WIDTH  read data.
REQ-024 s_axi_rresp  out  2  always 00.
REQ-025 s_axi_rlast  out  1  high on the final beat only.
REQ-026 s_axi_rvalid / s_axi_rready  out / in  1 each  R handshake.

Function
REQ-027 SHALL run the write and read paths as independent FSMs on a dual-port byte-enabled memory; both may be active in the same cycle.
REQ-028 Write FSM SHALL use states W_IDLE, W_BURST and W_RESP.
- W_IDLE: awready=1; an AW handshake captures id, addr, len, size and burst, drives awready=0 and wready=1 next cycle, and moves to W_BURST.
- W_BURST: each W handshake writes the bytes enabled by wstrb at word addr[ADDR_WIDTH-1:log2(STRB_WIDTH)].
- W_BURST: for INCR, addr advances by 2^size after each beat; for FIXED, addr holds.
- W_BURST: beat count decrements; the handshake at count 0 drives wready=0 and bvalid=1 next cycle and moves to W_RESP.
- W_RESP: bvalid is held until bready; the cycle after the B handshake, bvalid=0, awready=1 and the FSM is in W_IDLE.
REQ-029 Read FSM SHALL use states R_IDLE and R_BURST.
- R_IDLE: arready=1; an AR handshake in cycle T drives arready=0 and rvalid=1 with beat 0 data in T+1.
- R_BURST: each R handshake presents the next beat in the following cycle with no bubble; the address advances as for writes.
- R_BURST: rlast=1 exactly on beat arlen; after the last beat is accepted, rvalid=0 and arready=1 next cycle.
REQ-030 rvalid/rdata/rlast SHALL remain stable while rvalid=1 and rready=0; bvalid/bid SHALL remain stable while bready=0.
REQ-031 Address arithmetic SHALL be modulo 2^ADDR_WIDTH (wrap at top of memory); awlen=255 SHALL give 256 beats.
REQ-032 A read and a write to the same word in the same cycle SHALL return the old data on rdata.
REQ-033 Memory contents SHALL be uninitialised at power-up and SHALL NOT be cleared by rst.

Reset
REQ-034 While rst=1, at the next edge: awready, wready, bvalid, arready, rvalid and rlast SHALL be 0; bid, rid, bresp, rresp and rdata SHALL be 0; both FSMs SHALL be in IDLE.
REQ-035 awready and arready SHALL be 1 in the first cycle after rst deasserts; rst mid-burst SHALL abandon the burst with no response issued.

Verification
REQ-036 Single write: awaddr=0x10, awlen=0, wdata=0xDEADBEEF, wstrb=0xF -> bvalid 2 cycles after AW handshake with bid=awid and bresp=00; read 0x10 -> rdata=0xDEADBEEF, rlast=1, rvalid 1 cycle after AR handshake.
REQ-037 INCR burst: awlen=3 at 0x100, data 1..4 -> read arlen=3 returns 1,2,3,4 back-to-back with rready=1, rlast only on the 4th beat.
REQ-038 Byte strobes: write 0xFFFFFFFF, then 0x00000000 with wstrb=0x5 -> readback 0xFF00FF00.
REQ-039 Backpressure: rready toggling 1,0,0,1 and bready held 0 for 5 cycles -> data and ID stable, no beat lost or duplicated, awready stays 0 until the B handshake.
REQ-040 FIXED burst of 3 beats (A, B, C) to 0x20 -> word 0x20 holds C and 0x24 is unchanged; rst asserted mid read burst -> rvalid=0 next cycle, arready=1 after release, memory retained.
